reg_dump: RTL and testbench

REG_DUMP -- requirements
Module: reg_dump

---
 rtl/reg_dump.sv | 159 +++++++++++++++
 tb/tb_reg_dump.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_dump.sv
// Register dump streamer: walks a 16-entry register file through a poke read port and
// emits a framed byte stream (header, {addr, data hi, data lo} per selected reg, XOR checksum).
module reg_dump #(
    parameter logic [7:0] HEADER      = 8'hA5,
    parameter logic [3:0] ZERO_NIBBLE = 4'h0
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [15:0] reg_mask,
    output logic [3:0]  read_addrpoke,
    input  logic [15:0] read_datapoke,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        busy,
    output logic        done
);

    typedef enum logic [3:0] {
        IDLE,
        HDR,
        SCAN,
        SNAP,
        ADDR,
        DHI,
        DLO,
        CSUM,
        FIN
    } state_e;

    state_e      state_q;
    logic [15:0] mask_q;
    logic [15:0] hold_q;
    logic [3:0]  idx_q;
    logic [7:0]  csum_q;
    logic [3:0]  read_addrpoke_q;
    logic [7:0]  tx_data_q;
    logic        tx_valid_q;
    logic        busy_q;
    logic        done_q;

    logic        xfer_d;
    logic [7:0]  csum_d;
    logic        last_idx_d;

    // The checksum always folds in the byte currently on the bus, so the value
    // presented in CSUM already includes the final DLO byte.
    assign xfer_d     = tx_valid_q & tx_ready;
    assign csum_d     = csum_q ^ tx_data_q;
    assign last_idx_d = (idx_q == 4'hF);

    // NOTE: every register below is updated with <= so all of them sample the
    // pre-edge values; mixing in = here would make results depend on statement order.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q         <= IDLE;
            mask_q          <= 16'h0000;
            hold_q          <= 16'h0000;
            idx_q           <= 4'h0;
            csum_q          <= 8'h00;
            read_addrpoke_q <= 4'h0;
            tx_data_q       <= 8'h00;
            tx_valid_q      <= 1'b0;
            busy_q          <= 1'b0;
            done_q          <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        mask_q     <= reg_mask;
                        idx_q      <= 4'h0;
                        csum_q     <= 8'h00;
                        tx_data_q  <= HEADER;
                        tx_valid_q <= 1'b1;
                        busy_q     <= 1'b1;
                        state_q    <= HDR;
                    end
                end
                HDR: begin
                    if (xfer_d) begin
                        tx_valid_q <= 1'b0;
                        state_q    <= SCAN;
                    end
                end
                SCAN: begin
                    if (mask_q[idx_q]) begin
                        read_addrpoke_q <= idx_q;
                        state_q         <= SNAP;
                    end else if (last_idx_d) begin
                        tx_data_q  <= csum_q;
                        tx_valid_q <= 1'b1;
                        state_q    <= CSUM;
                    end else begin
                        idx_q <= idx_q + 4'd1;
                    end
                end
                SNAP: begin
                    // Snapshot taken here; later register writes cannot reach the frame.
                    hold_q     <= read_datapoke;
                    tx_data_q  <= {ZERO_NIBBLE, idx_q};
                    tx_valid_q <= 1'b1;
                    state_q    <= ADDR;
                end
                ADDR: begin
                    if (xfer_d) begin
                        csum_q    <= csum_d;
                        tx_data_q <= hold_q[15:8];
                        state_q   <= DHI;
                    end
                end
                DHI: begin
                    if (xfer_d) begin
                        csum_q    <= csum_d;
                        tx_data_q <= hold_q[7:0];
                        state_q   <= DLO;
                    end
                end
                DLO: begin
                    if (xfer_d) begin
                        csum_q <= csum_d;
                        if (last_idx_d) begin
                            tx_data_q <= csum_d;
                            state_q   <= CSUM;
                        end else begin
                            idx_q      <= idx_q + 4'd1;
                            tx_valid_q <= 1'b0;
                            state_q    <= SCAN;
                        end
                    end
                end
                CSUM: begin
                    if (xfer_d) begin
                        tx_valid_q <= 1'b0;
                        done_q     <= 1'b1;
                        state_q    <= FIN;
                    end
                end
                FIN: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    tx_valid_q <= 1'b0;
                    busy_q     <= 1'b0;
                    state_q    <= IDLE;
                end
            endcase
        end
    end

    assign read_addrpoke = read_addrpoke_q;
    assign tx_data       = tx_data_q;
    assign tx_valid      = tx_valid_q;
    assign busy          = busy_q;
    assign done          = done_q;

endmodule

// File: tb/tb_reg_dump.sv
// Scoreboard bench for reg_dump: each started frame pushes its expected bytes,
// a negedge monitor pops and compares every byte the DUT hands over.
module tb_reg_dump;

    localparam logic [7:0] HEADER = 8'hA5;
    localparam logic [3:0] ZN     = 4'h0;

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic [15:0] reg_mask;
    logic [3:0]  read_addrpoke;
    logic [15:0] read_datapoke;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        busy;
    logic        done;

    logic [15:0] regs [16];
    assign read_datapoke = regs[read_addrpoke];

    reg_dump #(.HEADER(HEADER), .ZERO_NIBBLE(ZN)) dut (
        .clock         (clock),
        .reset         (reset),
        .start         (start),
        .reg_mask      (reg_mask),
        .read_addrpoke (read_addrpoke),
        .read_datapoke (read_datapoke),
        .tx_data       (tx_data),
        .tx_valid      (tx_valid),
        .tx_ready      (tx_ready),
        .busy          (busy),
        .done          (done)
    );

    always #5 clock = ~clock;

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // kind: 0 header, 1 address, 2 data hi, 3 data lo, 4 checksum
    typedef struct {
        logic [7:0] b;
        int         kind;
    } exp_t;

    exp_t exp_q[$];
    exp_t cur;
    int   neg_cnt       = 0;
    int   last_xfer_neg = -100;
    int   done_cnt      = 0;
    int   frame_xfers   = 0;
    int   ready_mode    = 0;
    logic prev_stall    = 1'b0;
    logic prev_done     = 1'b0;
    logic [7:0] prev_data = 8'h00;

    initial tx_ready = 1'b1;
    always @(posedge clock) begin
        #1;
        case (ready_mode)
            0:       tx_ready = 1'b1;
            1:       tx_ready = ~tx_ready;
            default: tx_ready = 1'b0;
        endcase
    end

    always @(negedge clock) begin
        neg_cnt++;
        if (reset) begin
            prev_stall = 1'b0;
            prev_done  = 1'b0;
        end else begin
            if (prev_stall) begin
                check("hold_valid", {31'd0, tx_valid}, 32'd1);
                check("hold_data", {24'd0, tx_data}, {24'd0, prev_data});
            end
            if (prev_done) check("busy_after_done", {31'd0, busy}, 32'd0);
            if (tx_valid && tx_ready) begin
                if (exp_q.size() == 0) begin
                    check("extra_byte", {24'd0, tx_data}, 32'hFFFF_FFFF);
                end else begin
                    cur = exp_q.pop_front();
                    check("tx_byte", {24'd0, tx_data}, {24'd0, cur.b});
                    if (cur.kind == 1)
                        check("poke_addr", {28'd0, read_addrpoke}, {28'd0, cur.b[3:0]});
                end
                last_xfer_neg = neg_cnt;
                frame_xfers++;
            end
            if (done) begin
                check("done_gap", neg_cnt - last_xfer_neg, 32'd1);
                done_cnt++;
            end
            prev_stall = tx_valid && !tx_ready;
            prev_data  = tx_data;
            prev_done  = done;
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic push_frame(input logic [15:0] m);
        logic [7:0] cs;
        logic [7:0] a;
        cs = 8'h00;
        exp_q.push_back('{b: HEADER, kind: 0});
        for (int i = 0; i < 16; i++) begin
            if (m[i]) begin
                a = {ZN, 4'(i)};
                exp_q.push_back('{b: a, kind: 1});
                exp_q.push_back('{b: regs[i][15:8], kind: 2});
                exp_q.push_back('{b: regs[i][7:0], kind: 3});
                cs = cs ^ a ^ regs[i][15:8] ^ regs[i][7:0];
            end
        end
        exp_q.push_back('{b: cs, kind: 4});
    endtask

    task automatic start_frame(input logic [15:0] m);
        reg_mask = m;
        start    = 1'b1;
        push_frame(m);
        frame_xfers = 0;
        tick();
        start = 1'b0;
        check("valid_after_start", {31'd0, tx_valid}, 32'd1);
    endtask

    task automatic wait_done(input int budget, input int target);
        int n;
        n = 0;
        while (done_cnt < target && n < budget) begin
            tick();
            n++;
        end
        check("done_seen", {31'd0, done_cnt >= target}, 32'd1);
        check("queue_drained", exp_q.size(), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int d0;
        logic act;
        for (int i = 0; i < 16; i++) regs[i] = 16'(i * 16'h1111) ^ 16'h0F0F;

        // Reset with start asserted: reset must win.
        reset    = 1'b1;
        start    = 1'b1;
        reg_mask = 16'hFFFF;
        tick();
        tick();
        check("rst_valid", {31'd0, tx_valid}, 32'd0);
        check("rst_data", {24'd0, tx_data}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_poke", {28'd0, read_addrpoke}, 32'd0);
        reset = 1'b0;
        start = 1'b0;
        tick();
        check("idle_valid", {31'd0, tx_valid}, 32'd0);
        check("idle_busy", {31'd0, busy}, 32'd0);

        // Single register 0.
        regs[0] = 16'h1234;
        start_frame(16'h0001);
        wait_done(200, 1);

        // Only register 15: long scan, poke address F.
        regs[15] = 16'hBEEF;
        start_frame(16'h8000);
        wait_done(200, 2);

        // Empty mask: header and zero checksum only.
        start_frame(16'h0000);
        wait_done(100, 3);

        // Backpressure, mid-frame mask change, register write after snapshot.
        regs[1]    = 16'hC3A1;
        regs[13]   = 16'h5A7E;
        ready_mode = 1;
        start_frame(16'h2002);
        reg_mask = 16'hFFFF;
        n = 0;
        while (read_addrpoke != 4'hD && n < 200) begin
            tick();
            n++;
        end
        check("snap13_found", {31'd0, read_addrpoke == 4'hD}, 32'd1);
        tick();
        regs[13] = 16'hFFFF;
        wait_done(400, 4);
        ready_mode = 0;

        // Reset while presenting the data-high byte.
        regs[0] = 16'h1234;
        start_frame(16'h0001);
        n = 0;
        while (!(frame_xfers == 2 && tx_valid) && n < 100) begin
            tick();
            n++;
        end
        check("reached_dhi", {24'd0, tx_data}, 32'h12);
        reset = 1'b1;
        tick();
        check("midrst_valid", {31'd0, tx_valid}, 32'd0);
        check("midrst_busy", {31'd0, busy}, 32'd0);
        check("midrst_done", {31'd0, done}, 32'd0);
        exp_q.delete();
        reset = 1'b0;
        d0  = done_cnt;
        act = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (tx_valid || busy || done) act = 1'b1;
        end
        check("no_activity_after_reset", {31'd0, act}, 32'd0);
        check("no_done_after_reset", done_cnt, d0);
        regs[0] = 16'h0BAD;
        start_frame(16'h0001);
        wait_done(200, d0 + 1);

        // Start held high: back-to-back frames.
        d0       = done_cnt;
        reg_mask = 16'h0001;
        start    = 1'b1;
        push_frame(16'h0001);
        push_frame(16'h0001);
        tick();
        check("held_first_valid", {31'd0, tx_valid}, 32'd1);
        n = 0;
        while (done_cnt < d0 + 1 && n < 200) begin
            tick();
            n++;
        end
        check("held_idle_valid", {31'd0, tx_valid}, 32'd0);
        tick();
        check("held_restart", {31'd0, tx_valid}, 32'd1);
        check("held_restart_hdr", {24'd0, tx_data}, {24'd0, HEADER});
        start = 1'b0;
        wait_done(200, d0 + 2);
        for (int i = 0; i < 5; i++) tick();
        check("no_third_frame", done_cnt, d0 + 2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
